coproc_sched: RTL and testbench

In-order scheduler between the eXtension-interface issue/commit/result channels and the coprocessor execute unit. Buffers up to DEPTH offloaded instructions, holds each until commit or kill, dispatches only committed instructions to the execute unit one at a time, and returns write-back results on a valid/ready result channel. Killed instructions are dropped without execution.

---
 rtl/coproc_sched.sv | 179 +++++++++++++++++
 tb/tb_coproc_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_sched.sv
// In-order commit/kill buffer between the X-interface issue/commit channels and a
// single-issue coprocessor execute unit, returning write-back results on a valid/ready channel.
module coproc_sched #(
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [X_ID_WIDTH-1:0]  issue_req_id,
    input  logic [31:0]            issue_req_instr,
    input  logic [2*XLEN-1:0]      issue_req_rs,
    input  logic                   issue_req_writeback,
    input  logic                   commit_valid,
    input  logic [X_ID_WIDTH-1:0]  commit_id,
    input  logic                   commit_kill,
    output logic                   exe_valid,
    input  logic                   exe_ready,
    output logic [31:0]            exe_instr,
    output logic [2*XLEN-1:0]      exe_rs,
    input  logic                   exe_done,
    input  logic [XLEN-1:0]        exe_data,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [X_ID_WIDTH-1:0]  result_id,
    output logic [XLEN-1:0]        result_data,
    output logic [4:0]             result_rd,
    output logic                   result_we,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ENT_PEND, ENT_COMMIT, ENT_KILL} ent_state_t;
    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_RESULT} fsm_t;

    logic                  ent_valid [DEPTH];
    ent_state_t            ent_state [DEPTH];
    logic [X_ID_WIDTH-1:0] ent_id    [DEPTH];
    logic [31:0]           ent_instr [DEPTH];
    logic [2*XLEN-1:0]     ent_rs    [DEPTH];
    logic                  ent_wb    [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    fsm_t             state_q;
    fsm_t             state_d;

    logic       id_busy;
    logic       push;
    logic       pop;
    logic       capture;
    logic       head_valid;
    ent_state_t head_state;
    logic       head_wb;
    ent_state_t resolved_state;

    // A duplicate ID in flight would make commit matching ambiguous, so it is refused.
    always_comb begin
        id_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_id[i] == issue_req_id)) begin
                id_busy = 1'b1;
            end
        end
    end

    assign issue_ready = (count_q < CNT_W'(DEPTH)) && !id_busy;
    assign push        = issue_valid && issue_ready;
    assign count       = count_q;

    assign head_valid = ent_valid[head_q];
    assign head_state = ent_state[head_q];
    assign head_wb    = ent_wb[head_q];

    assign resolved_state = commit_kill ? ENT_KILL : ENT_COMMIT;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_valid) begin
                    if (head_state == ENT_KILL) begin
                        pop = 1'b1;
                    end else if (head_state == ENT_COMMIT) begin
                        state_d = S_DISPATCH;
                    end
                end
            end
            S_DISPATCH: begin
                if (exe_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (exe_done) begin
                    if (head_wb) begin
                        capture = 1'b1;
                        state_d = S_RESULT;
                    end else begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RESULT: begin
                if (result_ready) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign exe_valid    = (state_q == S_DISPATCH);
    assign exe_instr    = exe_valid ? ent_instr[head_q] : '0;
    assign exe_rs       = exe_valid ? ent_rs[head_q] : '0;
    assign result_valid = (state_q == S_RESULT);

    // Control state: pointers, occupancy, entry lifecycle, FSM and result channel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            result_id   <= '0;
            result_data <= '0;
            result_rd   <= '0;
            result_we   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_state[i] <= ENT_PEND;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid && ent_valid[i] && (ent_state[i] == ENT_PEND) &&
                    (ent_id[i] == commit_id)) begin
                    ent_state[i] <= resolved_state;
                end
            end
            if (push) begin
                ent_valid[tail_q] <= 1'b1;
                ent_state[tail_q] <= (commit_valid && (commit_id == issue_req_id))
                                     ? resolved_state : ENT_PEND;
                tail_q            <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                ent_valid[head_q] <= 1'b0;
                head_q            <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (capture) begin
                result_id   <= ent_id[head_q];
                result_data <= exe_data;
                result_rd   <= ent_instr[head_q][11:7];
                result_we   <= 1'b1;
            end
        end
    end

    // Entry payload is only meaningful while its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_id[tail_q]    <= issue_req_id;
            ent_instr[tail_q] <= issue_req_instr;
            ent_rs[tail_q]    <= issue_req_rs;
            ent_wb[tail_q]    <= issue_req_writeback;
        end
    end

endmodule

// File: tb/tb_coproc_sched.sv
// Scoreboard bench for coproc_sched: expected dispatches and results are queued
// when instructions are issued and compared when the DUT presents them.
`timescale 1ns/1ps
module tb_coproc_sched;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_req_id;
    logic [31:0] issue_req_instr;
    logic [63:0] issue_req_rs;
    logic        issue_req_writeback;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        exe_valid;
    logic        exe_ready;
    logic [31:0] exe_instr;
    logic [63:0] exe_rs;
    logic        exe_done;
    logic [31:0] exe_data;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [2:0]  count;

    always #5 clk = ~clk;

    coproc_sched #(.X_ID_WIDTH(4), .XLEN(32), .DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_req_id(issue_req_id), .issue_req_instr(issue_req_instr),
        .issue_req_rs(issue_req_rs), .issue_req_writeback(issue_req_writeback),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_instr(exe_instr), .exe_rs(exe_rs),
        .exe_done(exe_done), .exe_data(exe_data),
        .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
        .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
        .count(count)
    );

    typedef struct packed {logic [31:0] instr; logic [63:0] rs;} disp_t;
    typedef struct packed {logic [3:0] id; logic [4:0] rd; logic [31:0] data;} res_t;

    disp_t       disp_q[$];
    logic [31:0] data_q[$];
    res_t        res_q[$];
    int          disp_times[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    disp_t       mon_d;
    res_t        mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every dispatch and every accepted result must match the queue head.
    always @(negedge clk) begin
        if (!rst_i && exe_valid && exe_ready) begin
            disp_times.push_back(cyc);
            total++;
            if (disp_q.size() == 0) begin
                bad++;
                $display("FAIL dispatch_unexpected: got instr=%h, required no dispatch", exe_instr);
            end else begin
                mon_d = disp_q.pop_front();
                if ({exe_instr, exe_rs} !== {mon_d.instr, mon_d.rs}) begin
                    bad++;
                    $display("FAIL dispatch_payload: got %h/%h, required %h/%h",
                             exe_instr, exe_rs, mon_d.instr, mon_d.rs);
                end
            end
        end
        if (!rst_i && result_valid && result_ready) begin
            total++;
            if (res_q.size() == 0) begin
                bad++;
                $display("FAIL result_unexpected: got id=%0d data=%h, required no result",
                         result_id, result_data);
            end else begin
                mon_r = res_q.pop_front();
                if ({result_id, result_rd, result_data, result_we} !==
                    {mon_r.id, mon_r.rd, mon_r.data, 1'b1}) begin
                    bad++;
                    $display("FAIL result_payload: got id=%0d rd=%0d data=%h we=%b, required id=%0d rd=%0d data=%h we=1",
                             result_id, result_rd, result_data, result_we, mon_r.id, mon_r.rd, mon_r.data);
                end
            end
        end
    end

    // One clock; also plays the execute unit, answering each dispatch with exe_done next cycle.
    task automatic tick();
        logic fired;
        @(negedge clk);
        fired = exe_valid && exe_ready && !rst_i;
        @(posedge clk);
        #1;
        if (fired && data_q.size() > 0) begin
            exe_done = 1'b1;
            exe_data = data_q.pop_front();
        end else begin
            exe_done = 1'b0;
            exe_data = '0;
        end
    endtask

    task automatic issue(input logic [3:0] id, input logic [4:0] rd, input logic wb,
                         input logic exp, input logic cmt, input logic [31:0] data);
        logic [31:0] ins;
        logic [63:0] rs;
        res_t        r;
        ins = 32'h0000_002B | (32'(rd) << 7) | (32'(id) << 20);
        rs  = {32'($urandom), 32'($urandom)};
        issue_valid         = 1'b1;
        issue_req_id        = id;
        issue_req_instr     = ins;
        issue_req_rs        = rs;
        issue_req_writeback = wb;
        if (cmt) begin
            commit_valid = 1'b1;
            commit_id    = id;
            commit_kill  = 1'b0;
        end
        if (exp) begin
            disp_q.push_back({ins, rs});
            data_q.push_back(data);
            if (wb) begin
                r.id = id; r.rd = rd; r.data = data;
                res_q.push_back(r);
            end
        end
        tick();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic issue_ops(input logic [3:0] id, input logic [4:0] rd, input logic [63:0] rs,
                             input logic [31:0] data);
        res_t r;
        logic [31:0] ins;
        ins = 32'h0000_002B | (32'(rd) << 7) | (32'(id) << 20);
        issue_valid = 1'b1; issue_req_id = id; issue_req_instr = ins;
        issue_req_rs = rs; issue_req_writeback = 1'b1;
        disp_q.push_back({ins, rs});
        data_q.push_back(data);
        r.id = id; r.rd = rd; r.data = data;
        res_q.push_back(r);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic wait_empty(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (count == 0 && !exe_valid && !result_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_result(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        issue_req_id = 4'd0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", count); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready: got %b, required 1", issue_ready); end
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL reset_exe_valid: got %b, required 0", exe_valid); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid: got %b, required 0", result_valid); end
        total++;
        if ({result_id, result_data, result_rd, result_we, exe_instr, exe_rs} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got id=%0d data=%h rd=%0d we=%b instr=%h, required all 0",
                     result_id, result_data, result_rd, result_we, exe_instr);
        end
    endtask

    task automatic test_single();
        bit ok;
        issue_ops(4'd3, 5'd5, 64'h0000_0002_0000_0001, 32'hDEAD_BEEF);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count_after_issue: got %0d, required 1", count); end
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL single_pend_no_dispatch: got %b, required 0", exe_valid); end
        commit(4'd3, 1'b0);
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL single_exe_valid_c1: got %b, required 0", exe_valid); end
        tick();
        total++; if (exe_valid !== 1'b1) begin bad++; $display("FAIL single_exe_valid_c2: got %b, required 1", exe_valid); end
        tick();
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL single_result_early: got %b, required 0", result_valid); end
        wait_result(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_result_timeout: got none, required result_valid"); end
        total++;
        if ({result_id, result_rd, result_data, result_we} !== {4'd3, 5'd5, 32'hDEAD_BEEF, 1'b1}) begin
            bad++;
            $display("FAIL single_result: got id=%0d rd=%0d data=%h we=%b, required id=3 rd=5 data=deadbeef we=1",
                     result_id, result_rd, result_data, result_we);
        end
        tick();
        total++;
        if ({count, result_valid} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL single_drained: got count=%0d result_valid=%b, required 0/0", count, result_valid);
        end
    endtask

    task automatic test_kill();
        bit ok;
        issue(4'd1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(4'd2, 5'd2, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
        commit(4'd1, 1'b1);
        commit(4'd2, 1'b0);
        wait_empty(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL kill_drain: got count=%0d, required 0", count); end
        total++;
        if (disp_q.size() + res_q.size() != 0) begin
            bad++;
            $display("FAIL kill_pending: got %0d dispatches %0d results outstanding, required 0",
                     disp_q.size(), res_q.size());
        end
    endtask

    task automatic test_full_dup();
        bit ok;
        issue(4'd1, 5'd11, 1'b0, 1'b1, 1'b0, 32'h1);
        issue(4'd2, 5'd12, 1'b0, 1'b1, 1'b0, 32'h2);
        issue(4'd3, 5'd13, 1'b0, 1'b1, 1'b0, 32'h3);
        issue(4'd0, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d, required 4", count); end
        issue_req_id = 4'd9;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_issue_ready: got %b, required 0", issue_ready); end
        commit(4'd1, 1'b0);
        commit(4'd2, 1'b0);
        commit(4'd3, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (count == 3'd1 && !exe_valid) begin ok = 1'b1; break; end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL full_partial_drain: got count=%0d, required 1", count); end
        issue_req_id = 4'd0;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL dup_blocked: got %b, required 0", issue_ready); end
        issue_req_id = 4'd5;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL distinct_ready: got %b, required 1", issue_ready); end
        issue(4'd5, 5'd15, 1'b1, 1'b0, 1'b0, 32'h0);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL distinct_accepted: got count=%0d, required 2", count); end
        commit(4'd0, 1'b1);
        commit(4'd5, 1'b1);
        wait_empty(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_drain: got count=%0d, required 0", count); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] held;
        logic [3:0]  hid;
        result_ready = 1'b0;
        issue(4'd4, 5'd4, 1'b1, 1'b1, 1'b1, 32'hA0A0_0004);
        issue(4'd6, 5'd6, 1'b1, 1'b1, 1'b1, 32'hA0A0_0006);
        wait_result(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_result_timeout: got none, required result_valid"); end
        held = result_data;
        hid  = result_id;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) issue(4'd8, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
            else if (i == 1) issue(4'd9, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
            else tick();
            total++;
            if ({result_valid, result_data, result_id, exe_valid} !== {1'b1, 32'hA0A0_0004, 4'd4, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold_%0d: got valid=%b data=%h id=%0d exe_valid=%b, required 1/a0a00004/4/0",
                         i, result_valid, result_data, result_id, exe_valid);
            end
        end
        issue_req_id = 4'd11;
        #1;
        total++;
        if ({count, issue_ready} !== {3'd4, 1'b0}) begin
            bad++;
            $display("FAIL bp_full: got count=%0d ready=%b, required 4/0 (held %h id %0d)",
                     count, issue_ready, held, hid);
        end
        result_ready = 1'b1;
        commit(4'd8, 1'b1);
        commit(4'd9, 1'b1);
        wait_empty(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_drain: got count=%0d, required 0", count); end
    endtask

    task automatic test_same_cycle();
        bit ok;
        issue(4'd7, 5'd9, 1'b1, 1'b1, 1'b1, 32'h7777_0007);
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_c1: got %b, required 0", exe_valid); end
        tick();
        total++; if (exe_valid !== 1'b1) begin bad++; $display("FAIL same_cycle_c2: got %b, required 1", exe_valid); end
        wait_empty(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL same_cycle_drain: got count=%0d, required 0", count); end
        issue(4'd12, 5'd3, 1'b0, 1'b1, 1'b1, 32'h0000_0C0C);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (result_valid) ok = 1'b1;
            tick();
        end
        total++;
        if ({ok, count} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL no_wb: got result_seen=%b count=%0d, required 0/0", ok, count);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        disp_times.delete();
        issue(4'd10, 5'd1, 1'b1, 1'b1, 1'b1, 32'h0000_0010);
        issue(4'd11, 5'd2, 1'b1, 1'b1, 1'b1, 32'h0000_0011);
        issue(4'd13, 5'd3, 1'b1, 1'b1, 1'b1, 32'h0000_0013);
        wait_empty(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_drain: got count=%0d, required 0", count); end
        total++;
        if (disp_times.size() != 3) begin
            bad++;
            $display("FAIL b2b_dispatches: got %0d, required 3", disp_times.size());
        end else if (disp_times[1] - disp_times[0] != 4 || disp_times[2] - disp_times[1] != 4) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d,%0d cycles, required 4,4",
                     disp_times[1] - disp_times[0], disp_times[2] - disp_times[1]);
        end
    endtask

    task automatic test_done_ignored();
        exe_done = 1'b1;
        exe_data = 32'h0BAD_0BAD;
        tick();
        tick();
        total++;
        if ({result_valid, count, exe_valid} !== {1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL stray_done: got result_valid=%b count=%0d exe_valid=%b, required 0/0/0",
                     result_valid, count, exe_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        result_ready = 1'b0;
        issue(4'd14, 5'd7, 1'b1, 1'b1, 1'b1, 32'h1414_1414);
        issue(4'd15, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_result(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_result_timeout: got none, required result_valid"); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        res_q.delete();
        disp_q.delete();
        data_q.delete();
        result_ready = 1'b1;
        issue_req_id = 4'd14;
        #1;
        total++;
        if ({result_valid, count, exe_valid, result_id, result_data, issue_ready} !==
            {1'b0, 3'd0, 1'b0, 4'd0, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset: got rv=%b count=%0d ev=%b id=%0d data=%h ready=%b, required 0/0/0/0/0/1",
                     result_valid, count, exe_valid, result_id, result_data, issue_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before 100us");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        issue_valid = 1'b0; issue_req_id = '0; issue_req_instr = '0; issue_req_rs = '0;
        issue_req_writeback = 1'b0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
        exe_ready = 1'b1; exe_done = 1'b0; exe_data = '0;
        result_ready = 1'b1;
        test_reset();
        test_single();
        test_kill();
        test_full_dup();
        test_backpressure();
        test_same_cycle();
        test_back_to_back();
        test_done_ignored();
        test_reset_mid();
        total++;
        if (disp_q.size() + res_q.size() != 0) begin
            bad++;
            $display("FAIL final_scoreboard: got %0d dispatches %0d results outstanding, required 0",
                     disp_q.size(), res_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
